// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: opcodes, FSM states,
// default width and the divide-by-zero quotient.
package hilo_muldiv_unit_pkg;

  localparam int WIDTH_DEF = 32;
  localparam logic [WIDTH_DEF-1:0] DIVZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic op_is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a
// double-width accumulator ({hi_part, lo_part}).
module hilo_muldiv_unit_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_mul,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0]   add_sum_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] trial_s;
  logic             fits_s;

  // Multiply: add multiplicand on LSB then shift right; divide: shift left and trial-subtract.
  always_comb begin
    add_sum_s = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, ({WIDTH{acc_in[0]}} & opnd)};
    rem_sh_s  = acc_in[2*WIDTH-1:WIDTH-1];
    // Remainder stays below the divisor, so the difference fits in WIDTH bits when taken.
    trial_s   = rem_sh_s[WIDTH-1:0] - opnd;
    fits_s    = (rem_sh_s >= {1'b0, opnd});
    acc_out   = acc_in;
    if (is_mul) begin
      acc_out = {add_sum_s, acc_in[WIDTH-1:1]};
    end else if (fits_s) begin
      acc_out = {trial_s, acc_in[WIDTH-2:0], 1'b1};
    end else begin
      acc_out = {rem_sh_s[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO; stalls the front end while a
// result is pending and serves MFHI/MFLO through a combinational read port.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITER  = WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             RdHi,
  input  logic             RdLo,
  output logic [WIDTH-1:0] RdData,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic             Stall,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  localparam int CNT_W = $clog2(ITER);

  state_e             state_r, state_nxt_s;
  logic               load_s, step_s, fix_s, mthi_s, mtlo_s;
  logic [CNT_W-1:0]   count_r;
  logic [2*WIDTH-1:0] acc_r, acc_nxt_s, prod_s;
  logic [WIDTH-1:0]   opnd_r, a_raw_r, hi_r, lo_r;
  logic               is_mul_r, div_zero_r, neg_res_r, neg_rem_r;
  logic               busy_r, done_r, dbz_r;
  logic               a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, quot_s, rem_s, hi_fix_s, lo_fix_s;

  hilo_muldiv_unit_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_mul  (is_mul_r),
    .acc_in  (acc_r),
    .opnd    (opnd_r),
    .acc_out (acc_nxt_s)
  );

  // FSM state register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    fix_s       = 1'b0;
    mthi_s      = 1'b0;
    mtlo_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          case (Op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              load_s      = 1'b1;
              state_nxt_s = ST_ITER;
            end
            OP_MTHI: mthi_s = 1'b1;
            OP_MTLO: mtlo_s = 1'b1;
            default: state_nxt_s = ST_IDLE;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ITER: begin
        step_s = 1'b1;
        if (count_r == CNT_W'(ITER - 1)) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = ST_ITER;
        end
      end
      ST_FIX: begin
        fix_s       = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand magnitudes; the iteration runs unsigned and signs are restored at FIX.
  always_comb begin
    a_neg_s = op_is_signed(Op) & A[WIDTH-1];
    b_neg_s = op_is_signed(Op) & B[WIDTH-1];
    a_mag_s = a_neg_s ? -A : A;
    b_mag_s = b_neg_s ? -B : B;
  end

  // Iteration datapath: load at accept, one step per cycle in ITER.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count_r    <= '0;
      acc_r      <= '0;
      opnd_r     <= '0;
      a_raw_r    <= '0;
      is_mul_r   <= 1'b0;
      div_zero_r <= 1'b0;
      neg_res_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
    end else if (load_s) begin
      count_r    <= '0;
      a_raw_r    <= A;
      is_mul_r   <= op_is_mul(Op);
      div_zero_r <= (B == {WIDTH{1'b0}});
      neg_res_r  <= a_neg_s ^ b_neg_s;
      neg_rem_r  <= a_neg_s;
      if (op_is_mul(Op)) begin
        acc_r  <= {{WIDTH{1'b0}}, b_mag_s};
        opnd_r <= a_mag_s;
      end else begin
        acc_r  <= {{WIDTH{1'b0}}, a_mag_s};
        opnd_r <= b_mag_s;
      end
    end else if (step_s) begin
      acc_r   <= acc_nxt_s;
      count_r <= count_r + CNT_W'(1);
    end else begin
      acc_r   <= acc_r;
      count_r <= count_r;
    end
  end

  // Sign correction and divide-by-zero override of the final accumulator.
  always_comb begin
    prod_s   = neg_res_r ? -acc_r : acc_r;
    quot_s   = acc_r[WIDTH-1:0];
    rem_s    = acc_r[2*WIDTH-1:WIDTH];
    hi_fix_s = '0;
    lo_fix_s = '0;
    if (is_mul_r) begin
      hi_fix_s = prod_s[2*WIDTH-1:WIDTH];
      lo_fix_s = prod_s[WIDTH-1:0];
    end else if (div_zero_r) begin
      hi_fix_s = a_raw_r;
      lo_fix_s = WIDTH'(DIVZERO_Q);
    end else begin
      hi_fix_s = neg_rem_r ? -rem_s : rem_s;
      lo_fix_s = neg_res_r ? -quot_s : quot_s;
    end
  end

  // HI/LO architectural registers and status flags.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= fix_s;
      dbz_r  <= fix_s & ~is_mul_r & div_zero_r;
      if (fix_s) begin
        hi_r <= hi_fix_s;
        lo_r <= lo_fix_s;
      end else if (mthi_s) begin
        hi_r <= A;
      end else if (mtlo_s) begin
        lo_r <= A;
      end else begin
        hi_r <= hi_r;
      end
    end
  end

  // Read port: HI has priority over LO.
  always_comb begin
    if (RdHi) begin
      RdData = hi_r;
    end else if (RdLo) begin
      RdData = lo_r;
    end else begin
      RdData = '0;
    end
  end

  assign Stall     = busy_r & (Start | RdHi | RdLo);
  assign Busy      = busy_r;
  assign Done      = done_r;
  assign DivByZero = dbz_r;
  assign HiOut     = hi_r;
  assign LoOut     = lo_r;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench: directed cases plus randomized ops against an
// arithmetic reference model of MULT/MULTU/DIV/DIVU/MTHI/MTLO.
module tb_hilo_muldiv_unit;

  logic        Clk, Rst, Start, RdHi, RdLo;
  logic [2:0]  Op;
  logic [31:0] A, B, RdData, HiOut, LoOut;
  logic        Busy, Done, DivByZero, Stall;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  hilo_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .RdHi(RdHi), .RdLo(RdLo), .RdData(RdData), .Busy(Busy), .Done(Done),
    .DivByZero(DivByZero), .Stall(Stall), .HiOut(HiOut), .LoOut(LoOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference semantics straight from the arithmetic definitions.
  function automatic void ref_muldiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint      sp;
    logic [63:0] up;
    int          q, r;
    dbz = 1'b0;
    hi  = 32'd0;
    lo  = 32'd0;
    case (op)
      3'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); {hi, lo} = sp; end
      3'd1: begin up = {32'd0, a} * {32'd0, b}; {hi, lo} = up; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF; hi = a; dbz = 1'b1;
        end else if (op == 3'd3) begin
          lo = a / b; hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000; hi = 32'd0;
        end else begin
          q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
          lo = q; hi = r;
        end
      end
      default: begin hi = 32'd0; lo = 32'd0; end
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; A = a; B = b;
    tick();
    Start = 1'b0;
  endtask

  // Called in the first busy cycle; follows the op to its Done cycle and beyond.
  task automatic finish_op(input string tag, input logic [31:0] eh, input logic [31:0] el, input logic edbz);
    int cnt  = 0;
    int spur = 0;
    while (Busy === 1'b1 && cnt < 100) begin
      if (Done !== 1'b0 || DivByZero !== 1'b0) spur++;
      cnt++;
      tick();
    end
    chk({tag, "_busy_cycles"}, cnt, 32'd33);
    chk({tag, "_early_pulse"}, spur, 32'd0);
    chk({tag, "_done"}, 32'(Done), 32'd1);
    chk({tag, "_dbz"}, 32'(DivByZero), 32'(edbz));
    chk({tag, "_hi"}, HiOut, eh);
    chk({tag, "_lo"}, LoOut, el);
    RdHi = 1'b1; RdLo = 1'b1; #1;
    chk({tag, "_rd_hi_wins"}, RdData, eh);
    RdHi = 1'b0; #1;
    chk({tag, "_rd_lo"}, RdData, el);
    RdLo = 1'b0;
    m_hi = eh; m_lo = el;
    tick();
    chk({tag, "_done_drop"}, 32'(Done), 32'd0);
    chk({tag, "_dbz_drop"}, 32'(DivByZero), 32'd0);
  endtask

  initial begin
    logic [31:0] eh, el, ra, rb, hold;
    logic        ed;
    logic [2:0]  rop;
    int          cnt;

    Rst = 1'b1; Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0; RdHi = 1'b0; RdLo = 1'b0;
    tick(); tick();
    Rst = 1'b0;
    chk("rst_hi", HiOut, 32'd0);
    chk("rst_lo", LoOut, 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_dbz", 32'(DivByZero), 32'd0);
    chk("rst_rddata", RdData, 32'd0);
    RdHi = 1'b1; #1;
    chk("idle_rd_no_stall", 32'(Stall), 32'd0);
    RdHi = 1'b0;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    finish_op("mult_7_m3", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", 32'd0, 32'h8000_0000, 1'b0);
    issue(3'd3, 32'd5, 32'd0);
    finish_op("divu_by0", 32'd5, 32'hFFFF_FFFF, 1'b1);
    issue(3'd2, 32'hFFFF_FF00, 32'd0);
    finish_op("div_by0", 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1);

    // Stall on MFLO during busy, and a second Start held until the post-Done edge.
    issue(3'd0, 32'd3, 32'd4);
    tick();
    Start = 1'b1; Op = 3'd1; A = 32'd5; B = 32'd6; RdLo = 1'b1;
    #1;
    cnt = 0;
    while (Stall === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("stall_cycles", cnt, 32'd32);
    chk("stall_done", 32'(Done), 32'd1);
    chk("stall_busy_in_done", 32'(Busy), 32'd0);
    chk("stall_rddata", RdData, 32'd12);
    RdLo = 1'b0;
    tick();
    Start = 1'b0;
    chk("b2b_accept_busy", 32'(Busy), 32'd1);
    chk("b2b_accept_done", 32'(Done), 32'd0);
    finish_op("b2b_multu", 32'd0, 32'd30, 1'b0);

    // Asynchronous reset in the middle of a divide.
    issue(3'd3, 32'd100, 32'd7);
    repeat (10) tick();
    Rst = 1'b1; #1;
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_hi", HiOut, 32'd0);
    chk("midrst_lo", LoOut, 32'd0);
    tick();
    Rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    tick();
    chk("postrst_busy", 32'(Busy), 32'd0);
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    chk("mthi_hi", HiOut, 32'hDEAD_BEEF);
    chk("mthi_lo", LoOut, 32'd0);
    chk("mthi_busy", 32'(Busy), 32'd0);
    chk("mthi_done", 32'(Done), 32'd0);
    m_hi = 32'hDEAD_BEEF;
    issue(3'd5, 32'h1234_5678, 32'd0);
    chk("mtlo_lo", LoOut, 32'h1234_5678);
    chk("mtlo_hi", HiOut, 32'hDEAD_BEEF);
    m_lo = 32'h1234_5678;

    // Reserved opcodes change nothing.
    Start = 1'b1; Op = 3'd6; A = 32'h5555_AAAA; #1;
    chk("rsv_stall", 32'(Stall), 32'd0);
    tick();
    Op = 3'd7;
    tick();
    Start = 1'b0;
    chk("rsv_busy", 32'(Busy), 32'd0);
    chk("rsv_hi", HiOut, m_hi);
    chk("rsv_lo", LoOut, m_lo);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 5));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 17));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      if (rop == 3'd4 || rop == 3'd5) begin
        hold = (rop == 3'd4) ? m_lo : m_hi;
        issue(rop, ra, rb);
        if (rop == 3'd4) m_hi = ra; else m_lo = ra;
        chk("rnd_mt_hi", HiOut, m_hi);
        chk("rnd_mt_lo", LoOut, m_lo);
        chk("rnd_mt_busy", 32'(Busy), 32'd0);
      end else begin
        ref_muldiv(rop, ra, rb, eh, el, ed);
        issue(rop, ra, rb);
        finish_op($sformatf("rnd%0d_op%0d", i, rop), eh, el, ed);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
